// File: rtl/pulse_train_gen.sv
// pulse_train_gen
// Self-test stimulus source for the frequency meter. Within each window of W
// clock cycles it emits exactly N evenly spaced rising edges on sig_out.
// Edge placement uses a fractional accumulator: it adds 2N each cycle and
// toggles sig_out whenever the sum reaches W.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   start       one-cycle request, honoured only in IDLE
//   stop        synchronous abort, priority over everything but reset
//   continuous  latched at start; repeat windows until stop
//   edge_count  N, rising edges per window (latched at start)
//   window_len  W, window length in cycles (latched at start)
//   sig_out     generated signal (registered)
//   busy        high while running
//   done        one-cycle pulse per completed window
//   err         one-cycle pulse when a start request is rejected
module pulse_train_gen #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 27
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    input  logic [CNT_W-1:0] edge_count,
    input  logic [WIN_W-1:0] window_len,
    output logic             sig_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Width that holds both 2N and W without truncation.
    localparam int CMP_W = ((CNT_W + 1) > WIN_W) ? (CNT_W + 1) : WIN_W;
    // One extra bit so acc + 2N cannot overflow (acc < W and 2N <= W).
    localparam int SUM_W = CMP_W + 1;
    localparam int ACC_W = WIN_W + 1;
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   acc_nxt_s;
    logic [WIN_W-1:0]   wcnt_r;
    logic [WIN_W-1:0]   wcnt_nxt_s;
    logic [CNT_W-1:0]   n_r;
    logic [WIN_W-1:0]   w_r;
    logic               cont_r;
    logic               sig_out_r;
    logic               sig_nxt_s;
    logic               busy_r;
    logic               done_r;
    logic               done_nxt_s;
    logic               err_r;
    logic               err_nxt_s;
    logic               load_s;

    logic [CMP_W-1:0]   req_two_n_s;
    logic [CMP_W-1:0]   req_w_s;
    logic               reject_s;
    logic [SUM_W-1:0]   sum_s;
    logic [SUM_W-1:0]   w_ext_s;
    logic               toggle_s;
    logic               last_s;

    assign sig_out = sig_out_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;

    // Request legality check on the live inputs, operands zero-extended.
    always_comb begin
        req_two_n_s = CMP_W'({edge_count, 1'b0});
        req_w_s     = CMP_W'(window_len);
        reject_s    = (window_len == {WIN_W{1'b0}}) || (req_two_n_s > req_w_s);
    end

    // Accumulator step and window-end detection on the latched parameters.
    always_comb begin
        w_ext_s  = SUM_W'(w_r);
        sum_s    = SUM_W'(acc_r) + SUM_W'({n_r, 1'b0});
        toggle_s = (sum_s >= w_ext_s);
        last_s   = (wcnt_r == (w_r - WIN_ONE));
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        if (stop) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !reject_s) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RUN: begin
                    if (last_s && !cont_r) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Next values of the datapath and the registered outputs.
    always_comb begin
        acc_nxt_s  = acc_r;
        wcnt_nxt_s = wcnt_r;
        sig_nxt_s  = sig_out_r;
        done_nxt_s = 1'b0;
        err_nxt_s  = 1'b0;
        load_s     = 1'b0;
        if (stop) begin
            acc_nxt_s  = {ACC_W{1'b0}};
            wcnt_nxt_s = {WIN_W{1'b0}};
            sig_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && reject_s) begin
                        err_nxt_s = 1'b1;
                    end else if (start) begin
                        load_s     = 1'b1;
                        acc_nxt_s  = {ACC_W{1'b0}};
                        wcnt_nxt_s = {WIN_W{1'b0}};
                    end else begin
                        load_s = 1'b0;
                    end
                end
                RUN: begin
                    if (toggle_s) begin
                        acc_nxt_s = ACC_W'(sum_s - w_ext_s);
                        sig_nxt_s = ~sig_out_r;
                    end else begin
                        acc_nxt_s = ACC_W'(sum_s);
                    end
                    if (last_s) begin
                        wcnt_nxt_s = {WIN_W{1'b0}};
                        done_nxt_s = 1'b1;
                    end else begin
                        wcnt_nxt_s = wcnt_r + WIN_ONE;
                    end
                end
                default: begin
                    acc_nxt_s  = {ACC_W{1'b0}};
                    wcnt_nxt_s = {WIN_W{1'b0}};
                    sig_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            acc_r     <= {ACC_W{1'b0}};
            wcnt_r    <= {WIN_W{1'b0}};
            n_r       <= {CNT_W{1'b0}};
            w_r       <= {WIN_W{1'b0}};
            cont_r    <= 1'b0;
            sig_out_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            acc_r     <= acc_nxt_s;
            wcnt_r    <= wcnt_nxt_s;
            sig_out_r <= sig_nxt_s;
            busy_r    <= (state_nxt_s == RUN);
            done_r    <= done_nxt_s;
            err_r     <= err_nxt_s;
            if (load_s) begin
                n_r    <= edge_count;
                w_r    <= window_len;
                cont_r <= continuous;
            end else begin
                n_r    <= n_r;
                w_r    <= w_r;
                cont_r <= cont_r;
            end
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: table of run requests, per-cycle scoreboard of
// {sig_out, busy, done, err}, and an edge-counting meter on sig_out.
module tb_pulse_train_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [15:0] edge_count;
    logic [26:0] window_len;
    logic        sig_out;
    logic        busy;
    logic        done;
    logic        err;

    pulse_train_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .edge_count (edge_count),
        .window_len (window_len),
        .sig_out    (sig_out),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int w;
        bit cont;
        int nwin;
        bit exp_err;
        int exp_rises;
    } vec_t;

    vec_t     vecs[$];
    logic [3:0] exp_q[$];   // {sig_out, busy, done, err} per cycle
    int       checks = 0;
    int       fails  = 0;
    int       exp_n  = 0;
    int       rises  = 0;
    logic     sig_prev = 1'b0;
    int       cyc = 0;

    // Expected level inside a window: parity of toggles so far, where the
    // toggle count after k cycles is floor(k*2N/W).
    function automatic logic exp_sig(input int n, input int w, input int k);
        longint t;
        t = (longint'(k) * 2 * longint'(n)) / longint'(w);
        return t[0];
    endfunction

    task automatic push_run(input int n, input int w, input int nwin, input bit cont);
        for (int j = 0; j < nwin; j++) begin
            for (int k = 0; k < w; k++) begin
                exp_q.push_back({exp_sig(n, w, k), 1'b1, (j > 0 && k == 0), 1'b0});
            end
        end
        if (cont) exp_q.push_back(4'b0110);
        else      exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0000);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 20000) begin
            @(posedge clk);
            i++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
    endtask

    // Issue one start at the next edge; the scoreboard starts at that edge.
    task automatic issue_start(input int n, input int w, input bit cont);
        @(posedge clk);
        #1;
        start      = 1'b1;
        edge_count = 16'(n);
        window_len = 27'(w);
        continuous = cont;
        @(posedge clk);
    endtask

    task automatic apply_vec(input vec_t v);
        issue_start(v.n, v.w, v.cont);
        if (v.exp_err) begin
            exp_q.push_back(4'b0001);
            exp_q.push_back(4'b0000);
        end else begin
            exp_n = v.exp_rises;
            push_run(v.n, v.w, v.nwin, v.cont);
        end
        #1;
        start = 1'b0;
        if (!v.exp_err && v.cont) begin
            repeat (v.nwin * v.w) @(posedge clk);
            #1;
            stop = 1'b1;
            @(posedge clk);
            #1;
            stop = 1'b0;
        end
        wait_drain();
    endtask

    // Scoreboard compare and edge-count meter, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({sig_out, busy, done, err} !== e) begin
                fails++;
                $display("FAIL outputs cyc %0d: {sig,busy,done,err} got %b required %b",
                         cyc, {sig_out, busy, done, err}, e);
            end
        end
        if (sig_out && !sig_prev) rises++;
        if (done) begin
            checks++;
            if (rises != exp_n) begin
                fails++;
                $display("FAIL meter_edges: got %0d required %0d", rises, exp_n);
            end
            rises = 0;
        end else if (!busy) begin
            rises = 0;
        end
        sig_prev = sig_out;
    end

    initial begin
        int n;
        int w;
        int lo;
        reset_n    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        continuous = 1'b0;
        edge_count = 16'd0;
        window_len = 27'd0;
        @(posedge clk);
        exp_q.push_back(4'b0000);   // reset state
        exp_q.push_back(4'b0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_drain();

        //            n        w     cont nwin err  rises
        vecs.push_back('{1,      4,    1'b0, 1, 1'b0, 1});
        vecs.push_back('{2,      4,    1'b0, 1, 1'b0, 2});
        vecs.push_back('{3,      10,   1'b1, 5, 1'b0, 3});
        vecs.push_back('{3,      5,    1'b0, 1, 1'b1, 0});
        vecs.push_back('{0,      0,    1'b0, 1, 1'b1, 0});
        vecs.push_back('{1,      0,    1'b0, 1, 1'b1, 0});
        vecs.push_back('{0,      8,    1'b0, 1, 1'b0, 0});
        vecs.push_back('{5,      10,   1'b0, 1, 1'b0, 5});
        vecs.push_back('{6,      10,   1'b0, 1, 1'b1, 0});
        vecs.push_back('{32768,  100,  1'b0, 1, 1'b1, 0});
        vecs.push_back('{4,      16,   1'b1, 2, 1'b0, 4});
        vecs.push_back('{37,     1000, 1'b0, 1, 1'b0, 37});
        for (int r = 0; r < 4; r++) begin
            n  = int'($urandom_range(0, 40));
            lo = (n == 0) ? 1 : 2 * n;
            w  = int'($urandom_range(lo, 2 * n + 120));
            vecs.push_back('{n, w, 1'b0, 1, 1'b0, n});
        end
        foreach (vecs[i]) apply_vec(vecs[i]);

        // Abort on window cycle 5 of N=4, W=16: no done, sig_out low after.
        issue_start(4, 16, 1'b0);
        for (int k = 0; k < 6; k++) exp_q.push_back({exp_sig(4, 16, k), 3'b100});
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_drain();

        // Reset mid-run of N=3, W=10: all outputs low on the next edge.
        issue_start(3, 10, 1'b1);
        for (int k = 0; k < 4; k++) exp_q.push_back({exp_sig(3, 10, k), 3'b100});
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_drain();

        // Start during RUN with different parameters is ignored.
        issue_start(2, 8, 1'b0);
        exp_n = 2;
        push_run(2, 8, 1, 1'b0);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start      = 1'b1;
        edge_count = 16'd3;
        window_len = 27'd4;
        continuous = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        continuous = 1'b0;
        wait_drain();

        // Stop and an illegal start together in IDLE: stop wins, no err.
        @(posedge clk);
        #1;
        start      = 1'b1;
        stop       = 1'b1;
        edge_count = 16'd3;
        window_len = 27'd5;
        @(posedge clk);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
